// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: primary opcode values and the instruction-class encoding.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    CLS_R   = 2'd0,
    CLS_I   = 2'd1,
    CLS_J   = 2'd2,
    CLS_ILL = 2'd3
  } iclass_e;

endpackage

// File: rtl/instr_classify.sv
// Combinational opcode classifier: instruction class plus immediate-extension select.
module instr_classify
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  output iclass_e    iclass,
  output logic       ext_zero
);

  always_comb begin
    iclass   = CLS_ILL;
    ext_zero = 1'b0;
    unique case (opcode)
      OP_RTYPE: iclass = CLS_R;
      OP_J, OP_JAL: iclass = CLS_J;
      // Logical immediates are zero-extended; everything else sign-extends.
      OP_ANDI, OP_ORI, OP_XORI: begin
        iclass   = CLS_I;
        ext_zero = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_LUI, OP_LW, OP_SW:
        iclass = CLS_I;
      default: iclass = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered MIPS decode stage: one-entry valid/ready pipeline register that slices
// the instruction into fields and tags it with its class and extension select.
module instr_decode_stage
  import mips_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [5:0]         opcode,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [4:0]         shamt,
  output logic [5:0]         funct,
  output logic [15:0]        imm16,
  output logic [25:0]        jaddr,
  output logic               ext_zero,
  output logic [1:0]         iclass
);

  iclass_e            iclass_p0;
  logic               ext_zero_p0;

  logic               vld_p1;
  logic [INSTR_W-1:0] instr_p1;
  logic [PC_W-1:0]    pc_p1;
  iclass_e            iclass_p1;
  logic               ext_zero_p1;

  instr_classify u_classify (
    .opcode   (in_instr[31:26]),
    .iclass   (iclass_p0),
    .ext_zero (ext_zero_p0)
  );

  assign in_ready = !vld_p1 || out_ready;

  // p0 -> p1: pipeline register; flush squashes the entry, a consume with no refill empties it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      instr_p1    <= '0;
      pc_p1       <= '0;
      iclass_p1   <= CLS_R;
      ext_zero_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (in_valid && in_ready) begin
      vld_p1      <= 1'b1;
      instr_p1    <= in_instr;
      pc_p1       <= in_pc;
      iclass_p1   <= iclass_p0;
      ext_zero_p1 <= ext_zero_p0;
    end else if (vld_p1 && out_ready && !in_valid) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_pc    = pc_p1;
  assign opcode    = instr_p1[31:26];
  assign rs        = instr_p1[25:21];
  assign rt        = instr_p1[20:16];
  assign rd        = instr_p1[15:11];
  assign shamt     = instr_p1[10:6];
  assign funct     = instr_p1[5:0];
  assign imm16     = instr_p1[15:0];
  assign jaddr     = instr_p1[25:0];
  assign ext_zero  = ext_zero_p1;
  assign iclass    = iclass_p1;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage: stimulus queues expected entries, a negedge monitor checks each consumed output.
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] jaddr;
  logic        ext_zero;
  logic [1:0]  iclass;

  instr_decode_stage #(.PC_W(32), .INSTR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .imm16(imm16), .jaddr(jaddr), .ext_zero(ext_zero), .iclass(iclass)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [108:0] fields;
    bit           consec;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_pop = -10;

  function automatic logic [108:0] pack(input logic [31:0] pc, input logic [5:0] op,
      input logic [4:0] f_rs, input logic [4:0] f_rt, input logic [4:0] f_rd,
      input logic [4:0] f_sh, input logic [5:0] f_fn, input logic [15:0] f_imm,
      input logic [25:0] f_ja, input logic f_ext, input logic [1:0] f_cls);
    return {pc, op, f_rs, f_rt, f_rd, f_sh, f_fn, f_imm, f_ja, f_ext, f_cls};
  endfunction

  function automatic logic [108:0] dut_fields();
    return pack(out_pc, opcode, rs, rt, rd, shamt, funct, imm16, jaddr, ext_zero, iclass);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_hand(input logic [108:0] f, input bit consec);
    exp_t e;
    e.fields = f;
    e.consec = consec;
    q.push_back(e);
  endtask

  // Field slicing for the opcode sweep; class and ext select come from the table by hand.
  task automatic push_sliced(input logic [31:0] ins, input logic [31:0] pc,
                             input logic ext, input logic [1:0] cls, input bit consec);
    push_hand(pack(pc, ins[31:26], ins[25:21], ins[20:16], ins[15:11], ins[10:6],
                   ins[5:0], ins[15:0], ins[25:0], ext, cls), consec);
  endtask

  // Monitor: an output is consumed on the next edge whenever valid and ready are both high.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_output", {19'd0, dut_fields()}, 128'd0);
      end else begin
        e = q.pop_front();
        chk("decoded_entry", {19'd0, dut_fields()}, {19'd0, e.fields});
        if (e.consec) chk("no_bubble", 128'(cyc - last_pop), 128'd1);
        last_pop = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] tbl_instr [10];
  logic [1:0]  tbl_cls   [10];
  logic        tbl_ext   [10];
  logic [108:0] lw_f;

  initial begin
    tbl_instr[0] = 32'h11090003; tbl_cls[0] = 2'd1; tbl_ext[0] = 1'b0; // beq
    tbl_instr[1] = 32'h15090002; tbl_cls[1] = 2'd1; tbl_ext[1] = 1'b0; // bne
    tbl_instr[2] = 32'h25290001; tbl_cls[2] = 2'd1; tbl_ext[2] = 1'b0; // addiu
    tbl_instr[3] = 32'h29280005; tbl_cls[3] = 2'd1; tbl_ext[3] = 1'b0; // slti
    tbl_instr[4] = 32'h39280001; tbl_cls[4] = 2'd1; tbl_ext[4] = 1'b1; // xori
    tbl_instr[5] = 32'h3C01ABCD; tbl_cls[5] = 2'd1; tbl_ext[5] = 1'b0; // lui
    tbl_instr[6] = 32'hAD090008; tbl_cls[6] = 2'd1; tbl_ext[6] = 1'b0; // sw
    tbl_instr[7] = 32'h0C000010; tbl_cls[7] = 2'd2; tbl_ext[7] = 1'b0; // jal
    tbl_instr[8] = 32'h04000000; tbl_cls[8] = 2'd3; tbl_ext[8] = 1'b0; // opcode 0x01
    tbl_instr[9] = 32'h30AA0001; tbl_cls[9] = 2'd1; tbl_ext[9] = 1'b1; // andi

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_instr = 32'h3528F901;
    in_pc = 32'h40; out_ready = 1'b1;
    step(); step();
    @(negedge clk);
    chk("reset_out_valid", 128'(out_valid), 128'd0);
    chk("reset_fields", {19'd0, dut_fields()}, 128'd0);
    chk("reset_in_ready", 128'(in_ready), 128'd1);

    // ori, then addi/add/j back to back
    step();
    rst_n = 1'b1;
    push_hand(pack(32'h40, 6'h0D, 5'd9, 5'd8, 5'd31, 5'd4, 6'h01, 16'hF901, 26'h128F901, 1'b1, 2'd1), 1'b0);
    step();
    in_instr = 32'h2128FFFF; in_pc = 32'h44;
    push_hand(pack(32'h44, 6'h08, 5'd9, 5'd8, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h128FFFF, 1'b0, 2'd1), 1'b1);
    step();
    in_instr = 32'h01285020; in_pc = 32'h48;
    push_hand(pack(32'h48, 6'h00, 5'd9, 5'd8, 5'd10, 5'd0, 6'h20, 16'h5020, 26'h1285020, 1'b0, 2'd0), 1'b1);
    step();
    in_instr = 32'h08000100; in_pc = 32'h4C;
    push_hand(pack(32'h4C, 6'h02, 5'd0, 5'd0, 5'd0, 5'd4, 6'h00, 16'h0100, 26'h0000100, 1'b0, 2'd2), 1'b1);
    step();
    in_valid = 1'b0;
    step(); step();
    chk("drained_after_stream", 128'(out_valid), 128'd0);

    // stall: lw held for 3 cycles while andi waits at the input
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h8D090004; in_pc = 32'h100;
    lw_f = pack(32'h100, 6'h23, 5'd8, 5'd9, 5'd0, 5'd0, 6'h04, 16'h0004, 26'h1090004, 1'b0, 2'd1);
    push_hand(lw_f, 1'b0);
    step();
    in_instr = 32'h30AAFFFF; in_pc = 32'h104;
    push_hand(pack(32'h104, 6'h0C, 5'd5, 5'd10, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h0AAFFFF, 1'b1, 2'd1), 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 128'(in_ready), 128'd0);
      chk("stall_frozen", {19'd0, dut_fields()}, {19'd0, lw_f});
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();

    // flush on an empty stage with an offered word and no ready
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h39280001; in_pc = 32'h200; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_dropped", 128'(out_valid), 128'd0);
    step();

    // flush squashes a held, unconsumed entry
    in_valid = 1'b1; in_instr = 32'h2128FFFF; in_pc = 32'h210;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("held_before_flush", 128'(out_valid), 128'd1);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_squashed", 128'(out_valid), 128'd0);
    step();

    // illegal opcode is still delivered
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFC000000; in_pc = 32'h300;
    push_hand(pack(32'h300, 6'h3F, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h0, 1'b0, 2'd3), 1'b0);
    step();
    in_valid = 1'b0;
    step(); step();

    // opcode sweep streamed at full rate
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_instr = tbl_instr[i]; in_pc = 32'h400 + 32'(4 * i);
      push_sliced(tbl_instr[i], 32'h400 + 32'(4 * i), tbl_ext[i], tbl_cls[i], i != 0);
      step();
    end
    in_valid = 1'b0;
    step(); step();

    // reset wins during a stall with input offered
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h3528F901; in_pc = 32'h500;
    step();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("reset_mid_stall_valid", 128'(out_valid), 128'd0);
    chk("reset_mid_stall_fields", {19'd0, dut_fields()}, 128'd0);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step(); step();

    chk("scoreboard_empty", 128'(q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
